sha_job_scheduler: RTL
======================

SHA_JOB_SCHEDULER -- requirements
Module: sha_job_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 4095, is the maximum number of cycles to wait for core_done per block before the job is aborted.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  2  req[i] high means requester i has a message pending; held until done[i].
REQ-005 msg0, msg1  input  1024 each  padded message of requester 0 and 1; block 0 is bits [1023:512], block 1 is bits [511:0].
REQ-006 nblk0, nblk1  input  1 each  0 means a one-block job (block 0 only); 1 means a two-block job.
REQ-007 gnt  output  2  one-hot grant; marks the requester whose job currently owns the SHA-256 core.
REQ-008 done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 err  output  1  one-cycle pulse, coincident with done, when the job was aborted by timeout.
REQ-010 digest  output  256  final hash of the last completed job; held between jobs.
REQ-011 core_start  output  1  one-cycle pulse that launches the shared core on core_block.
REQ-012 core_block  output  512  block presented to the core; stable from core_start until core_done or timeout.
REQ-013 core_first  output  1  high with core_start for block 0, so the core loads the IV; low for block 1, so the core chains.
REQ-014 core_done  input  1  one-cycle pulse from the core; the block is finished.
REQ-015 core_hash  input  256  core chaining value; valid in the core_done cycle.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, LAUNCH, WAIT and RELEASE, with one state per cycle except WAIT.
REQ-018 IDLE: with any req high, the FSM SHALL select a requester, latch its msg and nblk, set gnt to that requester, clear blk_idx, and go to LAUNCH on the same edge.
REQ-019 Arbitration SHALL be round-robin: when both req are high, the requester not granted last wins; the pointer resets to favour requester 0.
REQ-020 LAUNCH: core_start=1, core_first=(blk_idx==0) and core_block=latched block blk_idx SHALL be driven for exactly one cycle; the timer clears; the FSM goes to WAIT.
REQ-021 WAIT on core_done with blk_idx < latched nblk: blk_idx SHALL increment and the FSM SHALL go to LAUNCH.
REQ-022 WAIT on core_done with blk_idx == latched nblk: digest SHALL be loaded from core_hash, done[granted] SHALL pulse in the next cycle, and the FSM SHALL go to RELEASE.
REQ-023 WAIT SHALL increment the timer each cycle; when the timer reaches TIMEOUT without core_done, digest SHALL be set to 0, done[granted] and err SHALL pulse, and the FSM SHALL go to RELEASE.
REQ-024 If core_done and the timeout occur in the same cycle, core_done SHALL take priority.
REQ-025 RELEASE: gnt SHALL clear, the round-robin pointer SHALL update, and the FSM SHALL go to IDLE; a new grant is possible no earlier than the cycle after IDLE.
REQ-026 core_done outside WAIT SHALL be ignored.
REQ-027 A req deassertion or a msg/nblk change while granted SHALL be ignored; the latched job runs to completion.
REQ-028 Latency: req seen at edge k → gnt at k+1 → core_start during cycle k+1..k+2 → done pulse in the cycle after the final core_done.
REQ-029 gnt, done and err SHALL never be asserted for more than one requester at a time.

Reset
REQ-030 On rst high, immediately and asynchronously: state=IDLE, gnt=0, done=0, err=0, core_start=0, core_first=0, core_block=0, digest=0, busy=0, blk_idx=0, timer=0, RR pointer=requester 0.
REQ-031 Reset mid-job SHALL abandon the job without a done pulse; after rst falls, the first clk edge evaluates req normally.

Verification
REQ-032 req=01, nblk0=0, msg0="abc" padded; core model returns ba7816bf...f20015ad after 70 cycles → one core_start with core_first=1, then done=01 and digest=ba7816bf...f20015ad.
REQ-033 req=10, nblk1=1 → two core_start pulses: first core_first=1 with msg1[1023:512], then core_first=0 with msg1[511:0]; a single done=10 after the second core_done.
REQ-034 req=11 held with back-to-back jobs → grants alternate 01,10,01,10; each gnt stays one-hot; IDLE lasts one cycle between jobs.
REQ-035 Core never returns core_done, TIMEOUT=15 → done and err pulse together 16 cycles after core_start, digest=0, and the FSM returns to IDLE.
REQ-036 rst pulsed during WAIT of block 1 → all outputs return to their reset values at once, no done pulse, and with req=01 still high a fresh grant follows on the first edge after rst falls.
REQ-037 Spurious core_done in IDLE, and core_done coinciding with the timeout → the first is ignored; the second completes the job normally with err=0.

Source files
------------

// File: rtl/sha_job_scheduler_if.sv
// Bundle between sha_job_scheduler, its two requesters and the shared SHA-256 core.
// The scheduler uses the slave modport; the environment (requesters plus core) uses master.
interface sha_job_scheduler_if;
    logic [1:0]    req;
    logic [1023:0] msg0;
    logic [1023:0] msg1;
    logic          nblk0;
    logic          nblk1;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic          err;
    logic [255:0]  digest;
    logic          busy;
    logic          core_start;
    logic [511:0]  core_block;
    logic          core_first;
    logic          core_done;
    logic [255:0]  core_hash;

    modport master (
        output req, msg0, msg1, nblk0, nblk1, core_done, core_hash,
        input  gnt, done, err, digest, busy, core_start, core_block, core_first
    );

    modport slave (
        input  req, msg0, msg1, nblk0, nblk1, core_done, core_hash,
        output gnt, done, err, digest, busy, core_start, core_block, core_first
    );
endinterface

// File: rtl/sha_job_scheduler.sv
// Round-robin scheduler sharing one SHA-256 block core between two requesters,
// sequencing one- or two-block jobs and aborting a block that exceeds TIMEOUT cycles.
module sha_job_scheduler #(
    parameter int TIMEOUT = 4095
) (
    input  logic               clk,
    input  logic               rst,
    sha_job_scheduler_if.slave bus
);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      done_q, done_d;
    logic            err_q, err_d;
    logic [255:0]    digest_q, digest_d;
    logic            busy_q, busy_d;
    logic            core_start_q, core_start_d;
    logic            core_first_q, core_first_d;
    logic [511:0]    core_block_q, core_block_d;
    logic [1023:0]   msg_q, msg_d;
    logic            nblk_q, nblk_d;
    logic            blk_idx_q, blk_idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            prio_q, prio_d;

    logic            pick_s;
    logic [TW-1:0]   timer_inc_s;
    logic            timeout_s;

    function automatic logic [511:0] block_sel(input logic [1023:0] msg, input logic idx);
        logic [511:0] blk;
        if (idx) begin
            blk = msg[511:0];
        end else begin
            blk = msg[1023:512];
        end
        return blk;
    endfunction

    assign timer_inc_s = timer_q + TW'(1);
    assign timeout_s   = (timer_inc_s == TIMEOUT_V);

    // Requester selection: prio_q names the requester that wins a tie.
    always_comb begin
        pick_s = 1'b0;
        if (bus.req == 2'b11) begin
            pick_s = prio_q;
        end else if (bus.req[1]) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Job sequencing: next state and next value of every register.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        done_d       = 2'b00;
        err_d        = 1'b0;
        digest_d     = digest_q;
        core_start_d = 1'b0;
        core_first_d = 1'b0;
        core_block_d = core_block_q;
        msg_d        = msg_q;
        nblk_d       = nblk_q;
        blk_idx_d    = blk_idx_q;
        timer_d      = timer_q;
        prio_d       = prio_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    msg_d        = pick_s ? bus.msg1 : bus.msg0;
                    nblk_d       = pick_s ? bus.nblk1 : bus.nblk0;
                    gnt_d        = pick_s ? 2'b10 : 2'b01;
                    blk_idx_d    = 1'b0;
                    // Start strobe is registered, so it is raised on entry to LAUNCH.
                    core_start_d = 1'b1;
                    core_first_d = 1'b1;
                    core_block_d = block_sel(pick_s ? bus.msg1 : bus.msg0, 1'b0);
                    state_d      = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    if (blk_idx_q < nblk_q) begin
                        blk_idx_d    = 1'b1;
                        core_start_d = 1'b1;
                        core_first_d = 1'b0;
                        core_block_d = block_sel(msg_q, 1'b1);
                        state_d      = S_LAUNCH;
                    end else begin
                        digest_d = bus.core_hash;
                        done_d   = gnt_q;
                        state_d  = S_RELEASE;
                    end
                end else if (timeout_s) begin
                    digest_d = '0;
                    done_d   = gnt_q;
                    err_d    = 1'b1;
                    state_d  = S_RELEASE;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            S_RELEASE: begin
                gnt_d   = 2'b00;
                prio_d  = ~gnt_q[1];
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 1'b0;
            digest_q     <= '0;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
            core_first_q <= 1'b0;
            core_block_q <= '0;
            msg_q        <= '0;
            nblk_q       <= 1'b0;
            blk_idx_q    <= 1'b0;
            timer_q      <= '0;
            prio_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            digest_q     <= digest_d;
            busy_q       <= busy_d;
            core_start_q <= core_start_d;
            core_first_q <= core_first_d;
            core_block_q <= core_block_d;
            msg_q        <= msg_d;
            nblk_q       <= nblk_d;
            blk_idx_q    <= blk_idx_d;
            timer_q      <= timer_d;
            prio_q       <= prio_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.digest     = digest_q;
    assign bus.busy       = busy_q;
    assign bus.core_start = core_start_q;
    assign bus.core_first = core_first_q;
    assign bus.core_block = core_block_q;
endmodule
